// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-organised memory slave with configurable wait states.
// Accepts byte/halfword/word transfers, responds with a two-cycle ERROR
// for out-of-range or misaligned accesses, and merges write lanes so a
// read immediately following a write to the same word sees the new bytes.
module ahb_lite_mem_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH);
    localparam logic [3:0]  WS         = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic          pend_valid;   // a legal data phase is outstanding
    logic          pend_write;
    logic [AW-1:0] pend_idx;
    logic [3:0]    pend_lanes;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          addr_err;
    logic          commit;
    logic [3:0]    addr_lanes;
    logic [AW-1:0] addr_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    // Protocol inputs this slave does not act on.
    logic unused_ok;
    assign unused_ok = &{1'b0, hburst, hprot, hmastlock, htrans[0]};

    assign addr_idx = haddr[AW+1:2];

    // New address phases are only taken when no data phase is being stretched.
    assign accept = hsel && hready && htrans[1] && (state == IDLE || state == ERR2);

    assign addr_err = ({1'b0, haddr} >= BYTE_LIMIT)
                   || (hsize > 3'b010)
                   || (hsize == 3'b001 && haddr[0])
                   || (hsize == 3'b010 && haddr[1:0] != 2'b00);

    // A write commits on the edge that ends its completing (IDLE) cycle.
    assign commit = (state == IDLE) && pend_valid && pend_write;

    // Byte lanes touched by the transfer in the current address phase.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        addr_lanes = 4'b0000;
        case (hsize)
            3'b000:  addr_lanes = 4'b0001 << haddr[1:0];
            3'b001:  addr_lanes = haddr[1] ? 4'b1100 : 4'b0011;
            3'b010:  addr_lanes = 4'b1111;
            default: addr_lanes = 4'b0000;
        endcase
    end

    // Read word for the next completing cycle, forwarding a same-edge write.
    always_comb begin
        rd_idx  = (state == WAIT) ? pend_idx : addr_idx;
        rd_word = mem[rd_idx];
        if (commit && pend_idx == rd_idx) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_lanes[b]) rd_word[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    // Storage update: only the selected lanes of the pending write change.
    // NOTE: the storage array has no reset; the control path is reset instead, which is what cancels a pending write.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_lanes[b]) mem[pend_idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    // Transfer state machine with registered response outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (hreset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_idx   <= '0;
            pend_lanes <= 4'b0000;
            hreadyout  <= 1'b1;
            hresp      <= 1'b0;
            hrdata     <= 32'h0;
        end else begin
            case (state)
                IDLE, ERR2: begin
                    if (accept) begin
                        pend_write <= hwrite;
                        pend_idx   <= addr_idx;
                        pend_lanes <= addr_lanes;
                        if (addr_err) begin
                            state      <= ERR1;
                            pend_valid <= 1'b0;
                            hreadyout  <= 1'b0;
                            hresp      <= 1'b1;
                            hrdata     <= 32'h0;
                        end else if (WS == 4'd0) begin
                            state      <= IDLE;
                            pend_valid <= 1'b1;
                            hreadyout  <= 1'b1;
                            hresp      <= 1'b0;
                            hrdata     <= hwrite ? 32'h0 : rd_word;
                        end else begin
                            state      <= WAIT;
                            wait_cnt   <= WS;
                            pend_valid <= 1'b1;
                            hreadyout  <= 1'b0;
                            hresp      <= 1'b0;
                            hrdata     <= 32'h0;
                        end
                    end else begin
                        state      <= IDLE;
                        pend_valid <= 1'b0;
                        hreadyout  <= 1'b1;
                        hresp      <= 1'b0;
                        hrdata     <= 32'h0;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state     <= IDLE;
                        wait_cnt  <= 4'd0;
                        hreadyout <= 1'b1;
                        hrdata    <= pend_write ? 32'h0 : rd_word;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ERR1: begin
                    state     <= ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench: three slaves (0, 2 and 3 wait states) on one bus,
// driven by a transfer engine whose expected responses come from a
// byte-addressed memory model and the bus response rules.
module tb_ahb_lite_mem_slave;

    localparam int DEPTH = 256;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;      // compare completed read data against exp_rd
        logic [31:0] exp_rd;
        logic [31:0] exp_mask;
    } xfer_t;

    logic        hclk;
    logic        hreset;
    logic [2:0]  sel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [1:0]  htrans;
    logic        hready;
    logic [31:0] hwdata;
    logic [2:0]  hro;
    logic [2:0]  hrs;
    logic [31:0] hrd [3];

    int errors = 0;
    int checks = 0;
    int ws_of [3] = '{0, 2, 3};

    logic [7:0] mm [3][1024];   // reference byte memory per slave
    xfer_t      xq [$];
    xfer_t      tbl [20];

    assign hready = &hro;

    ahb_lite_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .hsel(sel[0]), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
        .htrans(htrans), .hready(hready), .hwdata(hwdata),
        .hreadyout(hro[0]), .hresp(hrs[0]), .hrdata(hrd[0])
    );

    ahb_lite_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .hclk(hclk), .hreset(hreset), .hsel(sel[1]), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
        .htrans(htrans), .hready(hready), .hwdata(hwdata),
        .hreadyout(hro[1]), .hresp(hrs[1]), .hrdata(hrd[1])
    );

    ahb_lite_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset), .hsel(sel[2]), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
        .htrans(htrans), .hready(hready), .hwdata(hwdata),
        .hreadyout(hro[2]), .hresp(hrs[2]), .hrdata(hrd[2])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic s, input logic [1:0] t, input logic w,
                                 input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                                 input logic c, input logic [31:0] e, input logic [31:0] m);
        xfer_t x;
        x.sel = s; x.trans = t; x.write = w; x.size = sz; x.addr = a; x.wdata = d;
        x.chk = c; x.exp_rd = e; x.exp_mask = m;
        return x;
    endfunction

    // An accepted transfer is an error if out of range, oversized or misaligned.
    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        if (a >= 32'(4 * DEPTH)) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        if (sz == 3'd1 && a[0]) return 1'b1;
        if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input int k, input logic [31:0] a);
        int base;
        base = int'(a) & ~3;
        return {mm[k][base+3], mm[k][base+2], mm[k][base+1], mm[k][base]};
    endfunction

    // Little-endian: the byte at address ad travels on lane ad%4.
    task automatic model_write(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int nb;
        int ad;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++) begin
            ad = int'(a) + i;
            mm[k][ad] = d[8*(ad%4) +: 8];
        end
    endtask

    task automatic drive_addr(input int k, input xfer_t x);
        sel    = 3'b000;
        sel[k] = x.sel;
        htrans = x.trans;
        hwrite = x.write;
        hsize  = x.size;
        haddr  = x.addr;
    endtask

    task automatic drive_idle();
        sel    = 3'b000;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b000;
        haddr  = 32'h0;
    endtask

    // Random address-phase noise while the bus is stalled; must be ignored.
    task automatic drive_junk(input int k);
        sel    = 3'b000;
        sel[k] = 1'($urandom_range(0, 1));
        htrans = 2'($urandom_range(0, 3));
        hwrite = 1'($urandom_range(0, 1));
        hsize  = 3'($urandom_range(0, 2));
        haddr  = $urandom;
    endtask

    // Runs the queued transfers to slave k back to back and checks every cycle.
    // Entered between a rising edge and the following falling edge.
    task automatic run(input int k);
        xfer_t       cur;
        bit          cur_v;
        bit          cur_e;
        bit          done;
        int          ph;
        int          idx;
        logic        e_rdy;
        logic        e_rsp;
        logic [31:0] e_rd;
        cur_v = 1'b0; cur_e = 1'b0; done = 1'b0; ph = 0; idx = 0;
        cur = mk(0, 2'b00, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0, 32'h0);
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            e_rdy = 1'b1; e_rsp = 1'b0; e_rd = 32'h0;
            if (cur_v) begin
                if (cur_e) begin
                    e_rdy = (ph == 1);
                    e_rsp = 1'b1;
                end else if (ph < ws_of[k]) begin
                    e_rdy = 1'b0;
                end else if (!cur.write) begin
                    e_rd = model_word(k, cur.addr);
                end
            end
            if (e_rdy) begin
                if (idx < xq.size()) drive_addr(k, xq[idx]);
                else drive_idle();
            end else begin
                drive_junk(k);
            end
            hwdata = (cur_v && cur.write) ? cur.wdata : $urandom;
            @(negedge hclk);
            check($sformatf("s%0d hreadyout", k), 32'(hro[k]), 32'(e_rdy));
            check($sformatf("s%0d hresp", k), 32'(hrs[k]), 32'(e_rsp));
            check($sformatf("s%0d hrdata", k), hrd[k], e_rd);
            if (cur_v && !cur_e && e_rdy && !cur.write && cur.chk)
                check($sformatf("s%0d table read @%h", k, cur.addr), hrd[k] & cur.exp_mask,
                      cur.exp_rd & cur.exp_mask);
            @(posedge hclk);
            if (e_rdy) begin
                if (cur_v && !cur_e && cur.write) model_write(k, cur.addr, cur.size, cur.wdata);
                if (idx < xq.size()) begin
                    cur   = xq[idx];
                    idx++;
                    cur_v = cur.sel && cur.trans[1];
                    cur_e = is_err(cur.addr, cur.size);
                end else begin
                    cur_v = 1'b0;
                end
                ph = 0;
            end else begin
                ph++;
            end
            #1;
            if (!cur_v && idx >= xq.size()) done = 1'b1;
        end
        if (!done) check($sformatf("s%0d engine completion", k), 32'd0, 32'd1);
        drive_idle();
        xq.delete();
    endtask

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int    r;
        x = mk(0, 2'b00, 0, 3'b000, 32'h0, $urandom, 0, 32'h0, 32'h0);
        x.sel = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 9);
        x.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        x.write = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        r = $urandom_range(0, 19);
        if (r == 0)      x.addr = 32'h400 + 32'($urandom_range(0, 15));
        else if (r == 1) x.addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else             x.addr = 32'($urandom_range(0, 63));
        return x;
    endfunction

    task automatic preload(input int k);
        for (int w = 0; w < 16; w++)
            xq.push_back(mk(1, 2'b10, 1, 3'b010, 32'(w * 4), $urandom, 0, 32'h0, 32'h0));
    endtask

    initial begin
        // Directed vectors for the zero-wait slave, issued back to back.
        tbl[0]  = mk(1, 2'b10, 1, 3'b010, 32'h004, 32'h1122_3344, 0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 2'b10, 1, 3'b001, 32'h006, 32'hBEEF_0000, 0, 32'h0, 32'h0);
        tbl[2]  = mk(1, 2'b10, 0, 3'b010, 32'h004, 32'h0, 1, 32'hBEEF_3344, 32'hFFFF_FFFF);
        tbl[3]  = mk(1, 2'b10, 1, 3'b010, 32'h000, 32'h0000_0000, 0, 32'h0, 32'h0);
        tbl[4]  = mk(1, 2'b10, 1, 3'b000, 32'h001, 32'h0000_AA00, 0, 32'h0, 32'h0);
        tbl[5]  = mk(1, 2'b10, 0, 3'b010, 32'h000, 32'h0, 1, 32'h0000_AA00, 32'h0000_FF00);
        tbl[6]  = mk(1, 2'b10, 1, 3'b010, 32'h400, 32'hCAFE_F00D, 0, 32'h0, 32'h0);
        tbl[7]  = mk(1, 2'b10, 0, 3'b010, 32'h000, 32'h0, 1, 32'h0000_AA00, 32'hFFFF_FFFF);
        tbl[8]  = mk(1, 2'b10, 0, 3'b010, 32'h001, 32'h0, 0, 32'h0, 32'h0);
        tbl[9]  = mk(1, 2'b10, 1, 3'b001, 32'h002, 32'h5A5A_0000, 0, 32'h0, 32'h0);
        tbl[10] = mk(1, 2'b10, 0, 3'b010, 32'h000, 32'h0, 1, 32'h5A5A_AA00, 32'hFFFF_FFFF);
        tbl[11] = mk(1, 2'b00, 1, 3'b010, 32'h000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0);
        tbl[12] = mk(1, 2'b01, 1, 3'b010, 32'h000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0);
        tbl[13] = mk(0, 2'b10, 1, 3'b010, 32'h000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0);
        tbl[14] = mk(1, 2'b11, 0, 3'b010, 32'h000, 32'h0, 1, 32'h5A5A_AA00, 32'hFFFF_FFFF);
        tbl[15] = mk(1, 2'b10, 0, 3'b011, 32'h000, 32'h0, 0, 32'h0, 32'h0);
        tbl[16] = mk(1, 2'b10, 1, 3'b001, 32'h003, 32'h1234_5678, 0, 32'h0, 32'h0);
        tbl[17] = mk(1, 2'b10, 1, 3'b010, 32'h3FC, 32'h89AB_CDEF, 0, 32'h0, 32'h0);
        tbl[18] = mk(1, 2'b10, 0, 3'b000, 32'h3FF, 32'h0, 1, 32'h89AB_CDEF, 32'hFFFF_FFFF);
        tbl[19] = mk(1, 2'b10, 0, 3'b000, 32'h400, 32'h0, 0, 32'h0, 32'h0);

        hreset = 1'b1;
        drive_idle();
        hwdata    = 32'h0;
        hburst    = 3'b000;
        hprot     = 4'b0011;
        hmastlock = 1'b0;

        // Outputs while reset is held.
        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("s%0d reset hreadyout", k), 32'(hro[k]), 32'd1);
            check($sformatf("s%0d reset hresp", k), 32'(hrs[k]), 32'd0);
            check($sformatf("s%0d reset hrdata", k), hrd[k], 32'h0);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;

        // Zero-wait slave: preload, directed table, then random traffic.
        preload(0);
        run(0);
        for (int i = 0; i < 20; i++) xq.push_back(tbl[i]);
        run(0);
        for (int i = 0; i < 120; i++) xq.push_back(rand_xfer());
        run(0);

        // Two-wait-state slave: word read @0x08 plus random traffic.
        preload(1);
        xq.push_back(mk(1, 2'b10, 1, 3'b010, 32'h008, 32'hA5A5_0808, 0, 32'h0, 32'h0));
        xq.push_back(mk(1, 2'b10, 0, 3'b010, 32'h008, 32'h0, 1, 32'hA5A5_0808, 32'hFFFF_FFFF));
        run(1);
        for (int i = 0; i < 60; i++) xq.push_back(rand_xfer());
        run(1);

        // Three-wait-state slave: random traffic, then a known word at 0x10.
        preload(2);
        for (int i = 0; i < 40; i++) xq.push_back(rand_xfer());
        xq.push_back(mk(1, 2'b10, 1, 3'b010, 32'h010, 32'h1234_5678, 0, 32'h0, 32'h0));
        run(2);

        // Reset pulse during the second wait cycle of a write to 0x10.
        sel    = 3'b100;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'b010;
        haddr  = 32'h010;
        @(posedge hclk); #1;
        drive_idle();
        hwdata = 32'hDEAD_BEEF;
        check("abort wait1 hreadyout", 32'(hro[2]), 32'd0);
        @(posedge hclk); #1;
        check("abort wait2 hreadyout", 32'(hro[2]), 32'd0);
        hreset = 1'b1;
        #1;
        check("abort reset hreadyout", 32'(hro[2]), 32'd1);
        check("abort reset hresp", 32'(hrs[2]), 32'd0);
        check("abort reset hrdata", hrd[2], 32'h0);
        hreset = 1'b0;
        // First edge after reset release takes the read; old word must survive.
        xq.push_back(mk(1, 2'b10, 0, 3'b010, 32'h010, 32'h0, 1, 32'h1234_5678, 32'hFFFF_FFFF));
        run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 256, size of the memory in 32-bit words; valid byte range is 0 to 4*DEPTH-1.
REQ-002 SHALL have parameter WAIT_STATES, default 0, number of HREADYOUT-low cycles inserted before each OKAY data phase completes; legal range 0-15.
REQ-003 HCLK  input  1  single clock; all state updates on rising edge.
REQ-004 HRESET  input  1  asynchronous, active-high reset.
REQ-005 HSEL  input  1  slave select from decoder.
REQ-006 HADDR  input  32  byte address, address phase.
REQ-007 HWRITE  input  1  1 = write, 0 = read, address phase.
REQ-008 HSIZE  input  3  000 byte, 001 halfword, 010 word; other encodings are illegal.
REQ-009 HBURST, HPROT, HMASTLOCK  input  3/4/1  accepted and ignored.
REQ-010 HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-011 HREADY  input  1  bus ready (system HREADYOUT mux); gates address-phase sampling.
REQ-012 HWDATA  input  32  write data, data phase.
REQ-013 HREADYOUT  output  1  0 = extend current data phase.
REQ-014 HRESP  output  1  0 OKAY, 1 ERROR.
REQ-015 HRDATA  output  32  read data, data phase.

Function
REQ-016 Address phase SHALL be accepted only on a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE are latched at that edge.
REQ-017 IDLE/BUSY transfers, or HSEL=0 transfers, SHALL get a zero-wait OKAY response and SHALL have no side effect.
REQ-018 A transfer SHALL be flagged as an error under any of these conditions:
  - HADDR >= 4*DEPTH;
  - HSIZE > 010;
  - HSIZE=001 with HADDR[0]=1;
  - HSIZE=010 with HADDR[1:0]!=00.
REQ-019 State machine SHALL have states IDLE, WAIT, ERR1 and ERR2.
  - IDLE: no data phase pending, or final zero-wait cycle.
  - WAIT: down-counter from WAIT_STATES.
  - ERR1 / ERR2: two-cycle error response.
REQ-020 Accepted legal transfer with WAIT_STATES=0: SHALL complete in the next cycle with HREADYOUT=1, HRESP=0.
REQ-021 Accepted legal transfer with WAIT_STATES=N>0: SHALL drive HREADYOUT=0, HRESP=0 for exactly N cycles, then HREADYOUT=1 for one cycle.
REQ-022 Error transfer SHALL ignore WAIT_STATES and respond in two cycles:
  - ERR1: HREADYOUT=0, HRESP=1;
  - ERR2: HREADYOUT=1, HRESP=1;
  - no memory write occurs.
REQ-023 Write SHALL sample HWDATA on the edge ending the completing data-phase cycle; only lanes selected by latched HADDR[1:0] and HSIZE (little-endian) are updated, other bytes are unchanged.
REQ-024 Read SHALL drive HRDATA with the full 32-bit word at latched HADDR[31:2] during the completing cycle; HRDATA SHALL be 0 in every other cycle, including error and wait cycles.
REQ-025 A read whose data phase immediately follows a write to the same word SHALL return the newly written bytes.
REQ-026 A new address phase accepted in the completing cycle of the previous transfer SHALL start its own data phase the next cycle (pipelined, no bubble).
REQ-027 While HREADY=0, HADDR/HTRANS changes SHALL be ignored.

Reset
REQ-028 While HRESET=1, the block SHALL hold HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, and wait counter 0, asynchronously.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset during WAIT or ERR1 SHALL abort the transfer and SHALL NOT commit a pending write.
REQ-031 First address phase SHALL be acceptable on the first rising edge after HRESET deasserts.

Verification
REQ-032 Lane-merge write/read:
  - Stimulus: word write 0x11223344 @0x04; halfword write @0x06 with HWDATA=0xBEEF0000; word read @0x04.
  - Response: HRDATA=0xBEEF3344, HRESP=0.
REQ-033 Read-after-write back-to-back, no idle:
  - Stimulus: byte write HWDATA=0x0000AA00 @0x01, then NONSEQ word read @0x00 in the next address phase.
  - Response: HRDATA[15:8]=0xAA.
REQ-034 Wait states:
  - Stimulus: WAIT_STATES=2, word read @0x08.
  - Response: HREADYOUT=0 for exactly 2 cycles, then HREADYOUT=1 with valid HRDATA.
REQ-035 Out-of-range write:
  - Stimulus: DEPTH=256, word write @0x400.
  - Response: HREADYOUT 0 then 1, HRESP 1 in both cycles; readback @0x000 unchanged.
REQ-036 Misaligned access:
  - Stimulus: word read @0x01.
  - Response: two-cycle ERROR, HRDATA=0.
  - Stimulus: halfword @0x02.
  - Response: OKAY.
REQ-037 Reset mid-transfer:
  - Stimulus: WAIT_STATES=3; HRESET pulses high during the 2nd wait cycle of word write 0xDEADBEEF @0x10.
  - Response: HREADYOUT=1, HRESP=0 immediately; subsequent read @0x10 does not return 0xDEADBEEF.
